mdu_ctrl: RTL

- Parametrised multiply/divide unit with control decode; the next generation of the EX-stage ALU control for the MIPS core.
- Decodes the R-type funct codes that the base ALU control does not handle: MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO.
- Runs iterative multiply and divide over several cycles and owns the HI/LO registers.
- Sits beside the ALU in EX and raises a stall to the hazard unit while it is busy.

---
 rtl/mdu_pkg.sv | 26 ++
 rtl/mdu_decode.sv | 46 ++++
 rtl/mdu_ctrl.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the EX-stage multiply/divide unit.
//   - funct codes of the eight MDU R-type instructions
//   - ALUOP_RTYPE, the ALUOp value under which funct is meaningful
//   - mdu_state_t, the control FSM state type
package mdu_pkg;

  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MTLO  = 6'b010011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX,
    ST_DONE
  } mdu_state_t;

endpackage

// File: rtl/mdu_decode.sv
// mdu_decode: combinational funct decode for the multiply/divide unit.
// Also used by the hazard unit, so it carries no state.
// Ports:
//   funct     in  6  instruction funct field
//   mdu_op    out 1  funct is one of the eight MDU codes
//   is_mul    out 1  MULT / MULTU
//   is_div    out 1  DIV / DIVU
//   is_signed out 1  MULT / DIV
//   is_mf     out 1  MFHI / MFLO
//   is_mt     out 1  MTHI / MTLO
//   sel_hi    out 1  MF/MT targets HI (otherwise LO)
module mdu_decode
  import mdu_pkg::*;
(
  input  logic [5:0] funct,
  output logic       mdu_op,
  output logic       is_mul,
  output logic       is_div,
  output logic       is_signed,
  output logic       is_mf,
  output logic       is_mt,
  output logic       sel_hi
);

  always_comb begin
    mdu_op    = 1'b0;
    is_mul    = 1'b0;
    is_div    = 1'b0;
    is_signed = 1'b0;
    is_mf     = 1'b0;
    is_mt     = 1'b0;
    sel_hi    = 1'b0;
    case (funct)
      FN_MFHI:  begin mdu_op = 1'b1; is_mf = 1'b1; sel_hi = 1'b1; end
      FN_MTHI:  begin mdu_op = 1'b1; is_mt = 1'b1; sel_hi = 1'b1; end
      FN_MFLO:  begin mdu_op = 1'b1; is_mf = 1'b1; end
      FN_MTLO:  begin mdu_op = 1'b1; is_mt = 1'b1; end
      FN_MULT:  begin mdu_op = 1'b1; is_mul = 1'b1; is_signed = 1'b1; end
      FN_MULTU: begin mdu_op = 1'b1; is_mul = 1'b1; end
      FN_DIV:   begin mdu_op = 1'b1; is_div = 1'b1; is_signed = 1'b1; end
      FN_DIVU:  begin mdu_op = 1'b1; is_div = 1'b1; end
      default:  ;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: iterative multiply/divide unit with HI/LO ownership, sitting
// beside the ALU in EX. Multiply is shift-add, divide is restoring, one bit
// per cycle on magnitudes; signs are applied in a single FIX cycle.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   op_valid    R-type (ALUOp=10) instruction present in EX
//   funct       instruction funct field
//   src_a/src_b rs / rt operands
//   flush       kill the in-flight operation
//   mdu_op      funct is an MDU code (combinational)
//   stall       hold the pipeline (combinational)
//   busy        multiply/divide in progress
//   done        one-cycle pulse after HI/LO written by mul/div
//   mf_data     HI for MFHI, LO for MFLO, else 0 (combinational)
//   hi, lo      HI / LO registers
// WIDTH must be at least 4; CNT_W is derived and must not be overridden.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             mdu_op,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] mf_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  mdu_state_t           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  // Shared datapath: {accumulator, multiplier} for MUL, {remainder, quotient}
  // for DIV. opnd_q holds the multiplicand / divisor magnitude.
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_q, neg_d;       // product / quotient sign
  logic                 negr_q, negr_d;     // remainder sign (dividend sign)
  logic                 dz_q, dz_d;         // divide by zero

  logic dec_mdu_op, dec_is_mul, dec_is_div, dec_is_signed;
  logic dec_is_mf, dec_is_mt, dec_sel_hi;

  mdu_decode u_decode (
    .funct     (funct),
    .mdu_op    (dec_mdu_op),
    .is_mul    (dec_is_mul),
    .is_div    (dec_is_div),
    .is_signed (dec_is_signed),
    .is_mf     (dec_is_mf),
    .is_mt     (dec_is_mt),
    .sel_hi    (dec_sel_hi)
  );

  logic             idle, accept;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_trial;
  logic [2*WIDTH-1:0] mul_next, div_next, prod;
  logic [WIDTH-1:0] quo, rem;

  assign idle   = (state_q == ST_IDLE);
  assign accept = op_valid & dec_mdu_op & idle & ~flush;

  // Magnitudes; the most-negative value maps to itself, which read as
  // unsigned is the correct magnitude.
  assign a_neg = dec_is_signed & src_a[WIDTH-1];
  assign b_neg = dec_is_signed & src_b[WIDTH-1];
  assign a_mag = a_neg ? -src_a : src_a;
  assign b_mag = b_neg ? -src_b : src_b;

  // Shift-add step: add multiplicand into the upper half when the current
  // multiplier bit (LSB) is set, then shift the whole register right.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                  + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Restoring step: trial-subtract divisor from {rem, next dividend bit};
  // a negative result (top bit set) means restore and shift in a 0.
  assign div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, opnd_q};
  assign div_next  = div_trial[WIDTH]
                   ? {acc_q[2*WIDTH-2:0], 1'b0}
                   : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  assign prod = neg_q ? -acc_q : acc_q;
  assign quo  = acc_q[WIDTH-1:0];
  assign rem  = acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    negr_d   = negr_q;
    dz_d     = dz_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (dec_is_mt) begin
            if (dec_sel_hi) hi_d = src_a;
            else            lo_d = src_a;
          end else if (dec_is_mul || dec_is_div) begin
            cnt_d    = CNT_W'(WIDTH);
            is_div_d = dec_is_div;
            opnd_d   = b_mag;
            acc_d    = {{WIDTH{1'b0}}, a_mag};
            neg_d    = a_neg ^ b_neg;
            negr_d   = a_neg;
            dz_d     = dec_is_div && (src_b == '0);
            if (dec_is_div && (src_b == '0)) begin
              // Keep the raw dividend for HI; no sign fix-up applies.
              acc_d   = {{WIDTH{1'b0}}, src_a};
              neg_d   = 1'b0;
              negr_d  = 1'b0;
              state_d = ST_FIX;
            end else begin
              state_d = dec_is_div ? ST_DIV : ST_MUL;
            end
          end
        end
      end
      ST_MUL: begin
        acc_d = mul_next;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ST_FIX;
      end
      ST_DIV: begin
        acc_d = div_next;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        state_d = ST_DONE;
        if (dz_q) begin
          lo_d = '1;
          hi_d = acc_q[WIDTH-1:0];
        end else if (is_div_q) begin
          lo_d = neg_q  ? -quo : quo;
          hi_d = negr_q ? -rem : rem;
        end else begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Flush before commit abandons the operation; HI/LO stay as they were.
    if (flush && (state_q == ST_MUL || state_q == ST_DIV || state_q == ST_FIX)) begin
      state_d = ST_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      negr_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      negr_q   <= negr_d;
      dz_q     <= dz_d;
    end
  end

  assign mdu_op  = dec_mdu_op;
  assign stall   = op_valid & dec_mdu_op & ~idle;
  assign busy    = ~idle;
  assign done    = (state_q == ST_DONE);
  assign mf_data = dec_is_mf ? (dec_sel_hi ? hi_q : lo_q) : '0;
  assign hi      = hi_q;
  assign lo      = lo_q;

endmodule
